// File: rtl/cirno_pkg.sv
// Shared types for the instruction ROM path: loader state encoding and
// the address/instruction word types seen by both loader and fetch unit.
package cirno_pkg;

    localparam int CIRNO_ADDR_W = 9;
    localparam int CIRNO_INST_W = 9;

    typedef logic [CIRNO_ADDR_W-1:0] addr_t;
    typedef logic [CIRNO_INST_W-1:0] inst_t;

    typedef enum logic [2:0] {
        S_ADDR   = 3'd0,
        S_LEN    = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_LAUNCH = 3'd4,
        S_RUN    = 3'd5,
        S_ERR    = 3'd6
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a BASE/LEN/data/CSUM frame from the host,
// writes the data words into the instruction ROM and, once the XOR
// checksum matches, releases the fetch unit with a one-cycle init pulse.
module prog_loader
    import cirno_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int INST_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_data,
    output logic              in_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              fetch_unit_en,
    output logic              init,
    output logic [ADDR_W-1:0] startAddress,
    output logic              err
);

    // Remaining-count width must hold both any LEN value and the full
    // ROM depth (LEN = 0 encodes 2^ADDR_W words).
    localparam int CNT_W = ((INST_W > ADDR_W) ? INST_W : ADDR_W) + 1;

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [INST_W-1:0] r_acc;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [INST_W-1:0] r_mem_wdata;
    logic              r_fetch_en;
    logic              r_init;
    logic [ADDR_W-1:0] r_start_addr;
    logic              r_err;

    logic              w_accept;
    logic [CNT_W-1:0]  w_full_len;

    assign w_accept   = in_valid && in_ready;
    assign w_full_len = CNT_W'(1) << ADDR_W;

    // Ready is a pure state decode so the host never sees it depend on valid.
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_ADDR, S_LEN, S_DATA, S_CSUM: in_ready = 1'b1;
            default:                       in_ready = 1'b0;
        endcase
    end

    // Frame FSM, address/count/accumulator datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_ADDR;
            r_base       <= '0;
            r_cur_addr   <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_fetch_en   <= 1'b0;
            r_init       <= 1'b0;
            r_start_addr <= '0;
            r_err        <= 1'b0;
        end else begin
            // Write strobe and init are single-cycle pulses unless re-armed below.
            r_mem_we <= 1'b0;
            r_init   <= 1'b0;
            case (r_state)
                S_ADDR: begin
                    if (w_accept) begin
                        r_base     <= ADDR_W'(in_data);
                        r_cur_addr <= ADDR_W'(in_data);
                        r_state    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        r_cnt   <= (in_data == '0) ? w_full_len : CNT_W'(in_data);
                        r_acc   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_cur_addr;
                        r_mem_wdata <= in_data;
                        // Address wraps modulo the ROM depth by width alone.
                        r_cur_addr  <= r_cur_addr + ADDR_W'(1);
                        r_cnt       <= r_cnt - CNT_W'(1);
                        r_acc       <= r_acc ^ in_data;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (in_data == r_acc) begin
                            // init is raised for the single S_LAUNCH cycle.
                            r_init       <= 1'b1;
                            r_start_addr <= r_base;
                            r_state      <= S_LAUNCH;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_LAUNCH: begin
                    // Enable rises on the same edge that drops init.
                    r_fetch_en <= 1'b1;
                    r_state    <= S_RUN;
                end
                S_RUN: begin
                    if (load_req) begin
                        r_fetch_en <= 1'b0;
                        r_state    <= S_ADDR;
                    end
                end
                S_ERR: begin
                    if (load_req) begin
                        r_err   <= 1'b0;
                        r_state <= S_ADDR;
                    end
                end
                default: begin
                    r_fetch_en <= 1'b0;
                    r_err      <= 1'b0;
                    r_state    <= S_ADDR;
                end
            endcase
        end
    end

    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign fetch_unit_en = r_fetch_en;
    assign init          = r_init;
    assign startAddress  = r_start_addr;
    assign err           = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the stimulus side computes expected ROM
// writes from the frame rules and queues them; a monitor pops and compares
// every write the DUT presents.
module tb_prog_loader;

    localparam int AW    = 9;
    localparam int IW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_ready;
    logic          load_req = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;
    logic          fetch_unit_en;
    logic          init;
    logic [AW-1:0] startAddress;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;

    logic [AW+IW-1:0] exp_q[$];
    logic [IW-1:0]    data_q[$];

    prog_loader #(.ADDR_W(AW), .INST_W(IW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .load_req(load_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fetch_unit_en(fetch_unit_en), .init(init),
        .startAddress(startAddress), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write must match the head of the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {mem_addr, mem_wdata}, -1);
                end else begin
                    chk("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
                end
            end
            if (init && fetch_unit_en) chk("init_and_en_overlap", 1, 0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_fetch_en"}, fetch_unit_en, 0);
        chk({tag, "_init"}, init, 0);
        chk({tag, "_start"}, startAddress, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Offer one word after optional idle gaps; returns at the negedge after acceptance.
    task automatic send_word(input logic [IW-1:0] w, input int gap_pct);
        int budget;
        while (int'($urandom_range(99)) < gap_pct) @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        budget   = 0;
        while (!in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = IW'($urandom);
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Send a frame built from data_q; model derives addresses and checksum.
    task automatic run_frame(input int base, input int len, input bit bad,
                             input logic [IW-1:0] bad_csum, input int gap_pct);
        int            n;
        int            wr_start;
        logic [IW-1:0] csum;
        logic [AW-1:0] a;
        n    = (len == 0) ? DEPTH : len;
        csum = '0;
        for (int k = 0; k < n; k++) csum = csum ^ data_q[k];
        if (bad) csum = bad_csum;
        wr_start = wr_cnt;
        send_word(IW'(base), gap_pct);
        send_word(IW'(len), gap_pct);
        for (int k = 0; k < n; k++) begin
            a = AW'((base + k) % DEPTH);
            exp_q.push_back({a, data_q[k]});
            send_word(data_q[k], gap_pct);
        end
        send_word(csum, gap_pct);
        chk("write_count", wr_cnt - wr_start, n);
        chk("queue_drained", exp_q.size(), 0);
        if (!bad) begin
            chk("launch_init", init, 1);
            chk("launch_start", startAddress, base % DEPTH);
            chk("launch_en_low", fetch_unit_en, 0);
            chk("launch_ready_low", in_ready, 0);
            @(negedge clk);
            chk("run_init_low", init, 0);
            chk("run_en", fetch_unit_en, 1);
            chk("run_start_held", startAddress, base % DEPTH);
        end else begin
            chk("err_set", err, 1);
            chk("err_no_init", init, 0);
            chk("err_en_low", fetch_unit_en, 0);
            chk("err_ready_low", in_ready, 0);
        end
        data_q.delete();
    endtask

    task automatic fill_random(input int n);
        data_q.delete();
        for (int k = 0; k < n; k++) data_q.push_back(IW'($urandom));
    endtask

    task automatic fill_basic();
        data_q.delete();
        data_q.push_back(9'h101);
        data_q.push_back(9'h0AA);
        data_q.push_back(9'h155);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int len;

        // Reset state, during and after reset.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hi");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_lo");

        // Basic load.
        fill_basic();
        run_frame(9'h010, 3, 1'b0, 9'h000, 0);

        // Reload from RUN: enable drops on the next edge.
        pulse_load_req();
        chk("reload_en_low", fetch_unit_en, 0);
        chk("reload_ready", in_ready, 1);

        // Wrap-around.
        fill_random(4);
        run_frame(9'h1FE, 4, 1'b0, 9'h000, 0);
        pulse_load_req();

        // Bad checksum, then recovery.
        fill_basic();
        run_frame(9'h010, 3, 1'b1, 9'h000, 0);
        repeat (4) @(negedge clk);
        chk("err_sticky", err, 1);
        chk("err_en_stays_low", fetch_unit_en, 0);
        pulse_load_req();
        chk("err_cleared", err, 0);
        chk("err_ready_back", in_ready, 1);

        // Full length with stalls.
        fill_random(DEPTH);
        run_frame(int'($urandom_range(DEPTH - 1)), 0, 1'b0, 9'h000, 30);
        pulse_load_req();

        // Reset in the middle of DATA after 2 of 5 words.
        send_word(9'h080, 0);
        send_word(9'd5, 0);
        for (int k = 0; k < 2; k++) begin
            data_q.push_back(IW'($urandom));
            exp_q.push_back({AW'(9'h080 + k), data_q[k]});
            send_word(data_q[k], 0);
        end
        data_q.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst_hi");
        chk("midrst_queue", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst_lo");
        fill_random(1);
        run_frame(9'h040, 1, 1'b0, 9'h000, 0);
        pulse_load_req();

        // Random frames, each relaunching at its own base.
        for (int f = 0; f < 6; f++) begin
            base = int'($urandom_range(DEPTH - 1));
            len  = int'($urandom_range(20, 1));
            fill_random(len);
            run_frame(base, len, 1'b0, 9'h000, 25);
            repeat (int'($urandom_range(3))) @(negedge clk);
            chk("rand_run_en", fetch_unit_en, 1);
            pulse_load_req();
            chk("rand_reload_en_low", fetch_unit_en, 0);
        end

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
